// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and March-element constants for the RAM BIST
// controller. Element tables are indexed by elem_e (bit 0 = M0 ... bit 3 = M3).
package ram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    M0 = 2'd0,
    M1 = 2'd1,
    M2 = 2'd2,
    M3 = 2'd3
  } elem_e;

  typedef enum logic [1:0] {
    OP_W    = 2'd0,
    OP_R    = 2'd1,
    OP_WAIT = 2'd2
  } op_e;

  // Direction: only M2 walks the address space downwards.
  localparam logic [3:0] ELEM_DESC   = 4'b0100;
  // Elements that start each address with a read (M1, M2, M3).
  localparam logic [3:0] ELEM_HAS_RD = 4'b1110;
  // Elements that end each address with a write (M0, M1, M2).
  localparam logic [3:0] ELEM_HAS_WR = 4'b0111;
  // Background expected on reads: M2 reads all-1, M1/M3 read all-0.
  localparam logic [3:0] ELEM_RD_VAL = 4'b0100;
  // Background written: M1 writes all-1, M0/M2 write all-0.
  localparam logic [3:0] ELEM_WR_VAL = 4'b0010;

  function automatic elem_e next_elem(elem_e e);
    case (e)
      M0:      return M1;
      M1:      return M2;
      default: return M3;
    endcase
  endfunction

  // First operation issued at each address of an element.
  function automatic op_e first_op(elem_e e);
    return ELEM_HAS_RD[e] ? OP_R : OP_W;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: AW-bit up/down address counter for the March sequencer.
// load picks the direction and jumps to 0 (ascending) or D-1 (descending);
// step moves one address; is_last flags the terminal address of the walk.
module ram_bist_addr_gen #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          desc,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          is_last
);

  logic dir_desc;

  // Address and direction register; load wins over step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr     <= '0;
      dir_desc <= 1'b0;
    end else if (load) begin
      addr     <= desc ? '1 : '0;
      dir_desc <= desc;
    end else if (step) begin
      addr <= dir_desc ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign is_last = dir_desc ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March BIST initiator for one SyncRAM port.
// Runs M0 (up w0), M1 (up r0,w1), M2 (down r1,w0), M3 (up r0) over the whole
// address space, one RAM op per cycle, and reports pass/fail.
// Optional macro RAM_BIST_ERRCNT_EN: mismatches no longer stop the run; a
// saturating err_cnt is kept instead. Without it the run stops at the first
// mismatch and err_cnt is tied to 0.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int RD_LAT = 1,
  parameter int ECW    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [AW-1:0]  fail_addr,
  output logic [DW-1:0]  fail_data,
  output logic [ECW-1:0] err_cnt,
  output logic           ram_we,
  output logic           ram_re,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_din,
  input  logic [DW-1:0]  ram_dout
);

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

`ifdef RAM_BIST_ERRCNT_EN
  localparam bit STOP_ON_FAIL = 1'b0;
`else
  localparam bit STOP_ON_FAIL = 1'b1;
`endif

  state_e         state, nxt_state;
  elem_e          elem, nxt_elem;
  op_e            op, nxt_op;
  logic [WCW-1:0] wait_cnt, nxt_wait_cnt;

  logic           gen_load, gen_desc, gen_step, gen_last;
  logic [AW-1:0]  gen_addr;

  logic           start_run, addr_done, finish;
  logic           cmp_now, mismatch, fail_seen;
  logic [DW-1:0]  exp_rd;
  logic           nxt_we, nxt_re;
  logic [DW-1:0]  nxt_din;

  ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gen_load),
    .desc    (gen_desc),
    .step    (gen_step),
    .addr    (gen_addr),
    .is_last (gen_last)
  );

  // The address counter holds the address of the op in flight, so it is the
  // registered RAM address and the capture source for fail_addr.
  assign ram_addr = gen_addr;

  assign start_run = (state != RUN) && start;
  assign exp_rd    = {DW{ELEM_RD_VAL[elem]}};
  assign cmp_now   = (state == RUN) && (op == OP_WAIT) &&
                     (wait_cnt == WCW'(RD_LAT - 1));
  assign mismatch  = cmp_now && (ram_dout != exp_rd);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // FSM next state: start is only honoured outside RUN.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE, DONE: if (start) nxt_state = RUN;
      RUN:        if (finish) nxt_state = DONE;
      default:    nxt_state = IDLE;
    endcase
  end

  // March sequencer: chooses the next element/op/address and when to finish.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    nxt_elem     = elem;
    nxt_op       = op;
    nxt_wait_cnt = wait_cnt;
    gen_load     = 1'b0;
    gen_desc     = 1'b0;
    gen_step     = 1'b0;
    addr_done    = 1'b0;
    finish       = 1'b0;
    if (state != RUN) begin
      if (start) begin
        nxt_elem     = M0;
        nxt_op       = first_op(M0);
        nxt_wait_cnt = '0;
        gen_load     = 1'b1;
        gen_desc     = ELEM_DESC[M0];
      end
    end else begin
      case (op)
        OP_R: begin
          nxt_op       = OP_WAIT;
          nxt_wait_cnt = '0;
        end
        OP_WAIT: begin
          if (!cmp_now)                      nxt_wait_cnt = wait_cnt + 1'b1;
          else if (STOP_ON_FAIL && mismatch) finish = 1'b1;
          else if (ELEM_HAS_WR[elem])        nxt_op = OP_W;
          else                               addr_done = 1'b1;
        end
        default: addr_done = 1'b1;
      endcase
      if (addr_done) begin
        if (!gen_last) begin
          gen_step = 1'b1;
          nxt_op   = first_op(elem);
        end else if (elem == M3) begin
          finish = 1'b1;
        end else begin
          nxt_elem = next_elem(elem);
          nxt_op   = first_op(next_elem(elem));
          gen_load = 1'b1;
          gen_desc = ELEM_DESC[next_elem(elem)];
        end
      end
    end
  end

  // FSM outputs: status decode and next-cycle RAM strobes.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    nxt_we  = (nxt_state == RUN) && (nxt_op == OP_W);
    nxt_re  = (nxt_state == RUN) && (nxt_op == OP_R);
    nxt_din = nxt_we ? {DW{ELEM_WR_VAL[nxt_elem]}} : '0;
  end

  // Sequencer state and registered RAM strobes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks above use blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem     <= M0;
      op       <= OP_W;
      wait_cnt <= '0;
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_din  <= '0;
    end else begin
      elem     <= nxt_elem;
      op       <= nxt_op;
      wait_cnt <= nxt_wait_cnt;
      ram_we   <= nxt_we;
      ram_re   <= nxt_re;
      ram_din  <= nxt_din;
    end
  end

  // Result capture: cleared on (re)start, first mismatch kept, pass on finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass      <= 1'b0;
      fail_seen <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (start_run) begin
      pass      <= 1'b0;
      fail_seen <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      if (mismatch && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_addr <= gen_addr;
        fail_data <= ram_dout;
      end
      if (finish) pass <= !(fail_seen || mismatch);
    end
  end

`ifdef RAM_BIST_ERRCNT_EN
  // Saturating mismatch counter.
  always_ff @(posedge clk) begin
    if (!rst_n || start_run)           err_cnt <= '0;
    else if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: self-checking bench for ram_bist_ctrl with a behavioural
// SyncRAM (read latency 1) that can model one stuck-at bit.
// Honours RAM_BIST_ERRCNT_EN for the expected cycle counts and err_cnt.
module tb_ram_bist_ctrl;

  localparam int AW     = 4;
  localparam int DW     = 4;
  localparam int RD_LAT = 1;
  localparam int ECW    = 8;
  localparam int D      = 1 << AW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           busy, done, pass;
  logic [AW-1:0]  fail_addr;
  logic [DW-1:0]  fail_data;
  logic [ECW-1:0] err_cnt;
  logic           ram_we, ram_re;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  ram_din;
  logic [DW-1:0]  ram_dout;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .ECW(ECW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .err_cnt   (err_cnt),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Behavioural SyncRAM with an optional stuck-at bit on the read path.
  logic [DW-1:0] mem [D];
  bit            fault_on;
  logic [AW-1:0] f_addr;
  int            f_bit;
  logic          f_val;

  function automatic logic [DW-1:0] faulty(logic [AW-1:0] a, logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (fault_on && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= faulty(ram_addr, mem[ram_addr]);
  end

  // Per-cycle strobe monitor.
  typedef struct packed {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  op_t trace[$];
  bit  tracing;
  int  both_hi;
  int  post_done;

  always @(negedge clk) begin
    if (ram_we && ram_re) both_hi++;
    if (done && (ram_we || ram_re)) post_done++;
    if (tracing && (ram_we || ram_re)) trace.push_back(op_t'{ram_we, ram_re, ram_addr, ram_din});
  end

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {3'b0, busy, done, pass, fail_addr, fail_data, err_cnt,
            ram_we, ram_re, ram_addr, ram_din};
  endfunction

  // Pulse start and count busy cycles until done (bounded).
  task automatic run_once(output int busy_cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit            f_on;
    logic [AW-1:0] fa;
    int            fb;
    logic          fv;
    int            cyc;     // busy cycles in fail-stop mode
    logic          pass;
    logic [AW-1:0] exp_fa;
    logic [DW-1:0] exp_fd;
    int            errs;    // mismatches over a full march
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   cyc, exp_cyc, exp_err, bad;
    op_t  exp_q[$];

    vecs[0] = '{0, 4'h0, 0, 1'b0, 144, 1'b1, 4'h0, 4'h0, 0};  // clean RAM
    vecs[1] = '{1, 4'h5, 0, 1'b1,  33, 1'b0, 4'h5, 4'h1, 2};  // SA1 -> M1 r0
    vecs[2] = '{1, 4'h5, 0, 1'b0,  96, 1'b0, 4'h5, 4'hE, 1};  // SA0 -> M2 r1
    vecs[3] = '{1, 4'h0, 3, 1'b1,  18, 1'b0, 4'h0, 4'h8, 2};  // first M1 read
    vecs[4] = '{1, 4'hF, 2, 1'b0,  66, 1'b0, 4'hF, 4'hB, 1};  // first M2 read
    vecs[5] = '{1, 4'h0, 1, 1'b0, 111, 1'b0, 4'h0, 4'hD, 1};  // last M2 read
    vecs[6] = '{1, 4'hF, 0, 1'b1,  63, 1'b0, 4'hF, 4'h1, 2};  // last M1 read

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; fault_on = 0; f_addr = '0; f_bit = 0; f_val = 1'b0;
    tracing = 0; both_hi = 0; post_done = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'h0);
    rst_n = 1'b1;

    // Table-driven runs.
    for (int i = 0; i < 7; i++) begin
      fault_on = vecs[i].f_on; f_addr = vecs[i].fa; f_bit = vecs[i].fb; f_val = vecs[i].fv;
      post_done = 0;
`ifdef RAM_BIST_ERRCNT_EN
      exp_cyc = 144; exp_err = vecs[i].errs;
`else
      exp_cyc = vecs[i].cyc; exp_err = 0;
`endif
      run_once(cyc);
      check($sformatf("v%0d busy_cycles", i), cyc, exp_cyc);
      check($sformatf("v%0d done", i), done, 1);
      check($sformatf("v%0d busy_low", i), busy, 0);
      check($sformatf("v%0d pass", i), pass, vecs[i].pass);
      check($sformatf("v%0d fail_addr", i), fail_addr, vecs[i].exp_fa);
      check($sformatf("v%0d fail_data", i), fail_data, vecs[i].exp_fd);
      check($sformatf("v%0d err_cnt", i), err_cnt, exp_err);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d strobes_after_done", i), post_done, 0);
      check($sformatf("v%0d done_holds", i), done, 1);
    end

    // Restart from a failed DONE clears results in the first RUN cycle.
    fault_on = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart_first_cycle", {busy, done, pass, fail_addr, fail_data, err_cnt},
          {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h0});
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    check("restart_pass", {done, pass}, 2'b11);

    // start pulsed while busy is ignored.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (busy) cyc++;
      start = (i == 20);
      @(negedge clk);
    end
    start = 1'b0;
    check("start_while_busy_cycles", cyc, 144);
    check("start_while_busy_pass", {done, pass}, 2'b11);

    // Address trace of a clean run.
    trace.delete();
    tracing = 1;
    run_once(cyc);
    tracing = 0;
    for (int a = 0; a < D; a++) exp_q.push_back(op_t'{1'b1, 1'b0, AW'(a), 4'h0});
    for (int a = 0; a < D; a++) begin
      exp_q.push_back(op_t'{1'b0, 1'b1, AW'(a), 4'h0});
      exp_q.push_back(op_t'{1'b1, 1'b0, AW'(a), 4'hF});
    end
    for (int a = D - 1; a >= 0; a--) begin
      exp_q.push_back(op_t'{1'b0, 1'b1, AW'(a), 4'h0});
      exp_q.push_back(op_t'{1'b1, 1'b0, AW'(a), 4'h0});
    end
    for (int a = 0; a < D; a++) exp_q.push_back(op_t'{1'b0, 1'b1, AW'(a), 4'h0});
    check("trace_length", trace.size(), exp_q.size());
    bad = 0;
    for (int k = 0; k < exp_q.size() && k < trace.size(); k++) begin
      if (trace[k].we !== exp_q[k].we || trace[k].re !== exp_q[k].re ||
          trace[k].addr !== exp_q[k].addr ||
          (exp_q[k].we && trace[k].din !== exp_q[k].din)) bad++;
    end
    check("trace_bad_entries", bad, 0);
    check("we_re_overlap", both_hi, 0);

    // Reset at cycle 50 of a run, then a fresh run.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    check("busy_at_cycle_50", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", all_outs(), 32'h0);
    rst_n = 1'b1;
    run_once(cyc);
    check("post_reset_cycles", cyc, 144);
    check("post_reset_pass", {done, pass}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
